// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store sequencer between execute and the memory data port
module load_store_unit #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_error,
  output logic [1:0]  resp_cause,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_write_enable,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t st, st_n;
  logic store_r;
  logic [2:0] fn_r;
  logic [CW-1:0] cnt;
  logic illegal, misaligned, reject, accept, last;
  logic [31:0] ext, wmask;
  always_comb begin
    illegal = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_store && req_funct3[2]);
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    reject = illegal || misaligned;
    accept = req_valid && st == IDLE;
    last = st == ACCESS && cnt == '0;
    st_n = accept ? (reject ? RESP : ACCESS) : last ? RESP : (st == RESP && resp_ready) ? IDLE : st;
    ext = fn_r[1:0] == 2'b00 ? {{24{~fn_r[2] & mem_data_out[7]}}, mem_data_out[7:0]} :
          fn_r[1:0] == 2'b01 ? {{16{~fn_r[2] & mem_data_out[15]}}, mem_data_out[15:0]} : mem_data_out;
    wmask = req_funct3[1:0] == 2'b00 ? {24'b0, req_wdata[7:0]} :
            req_funct3[1:0] == 2'b01 ? {16'b0, req_wdata[15:0]} : req_wdata;
    mem_write_enable = !(last && store_r) ? 3'b000 :
                       fn_r[1:0] == 2'b00 ? 3'b100 : fn_r[1:0] == 2'b01 ? 3'b010 : 3'b001;
    req_ready = st == IDLE;
    resp_valid = st == RESP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      store_r <= 1'b0;
      fn_r <= 3'b000;
      cnt <= '0;
      mem_addr <= 32'b0;
      mem_data_in <= 32'b0;
      resp_rdata <= 32'b0;
      resp_rd <= 5'b0;
      resp_error <= 1'b0;
      resp_cause <= 2'b00;
    end else begin
      st <= st_n;
      if (accept) begin
        resp_rd <= req_rd;
        resp_rdata <= 32'b0;
        resp_error <= reject;
        resp_cause <= illegal ? 2'b10 : misaligned ? 2'b01 : 2'b00;
        if (!reject) begin
          store_r <= req_store;
          fn_r <= req_funct3;
          mem_addr <= req_addr;
          cnt <= CW'(ACCESS_CYCLES - 1);
          if (req_store) mem_data_in <= wmask;
        end
      end else if (st == ACCESS) begin
        cnt <= cnt - 1'b1;
        if (last && !store_r) resp_rdata <= ext;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table and random checks of three load_store_unit instances (ACCESS_CYCLES 1..3)
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  logic req_valid [1:3];
  logic resp_ready [1:3];
  logic rdy [1:3], rv [1:3], rerr [1:3];
  logic req_store;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, mdo;
  logic [4:0] req_rd;
  logic [31:0] rdata [1:3], maddr [1:3], mdin [1:3];
  logic [4:0] rrd [1:3];
  logic [1:0] cause [1:3];
  logic [2:0] we [1:3];
  int pass_cnt = 0, tot = 0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : gd
    load_store_unit #(.ACCESS_CYCLES(g)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid[g]), .req_ready(rdy[g]),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(rv[g]),
      .resp_ready(resp_ready[g]), .resp_rdata(rdata[g]), .resp_rd(rrd[g]),
      .resp_error(rerr[g]), .resp_cause(cause[g]), .mem_addr(maddr[g]),
      .mem_write_enable(we[g]), .mem_data_in(mdin[g]), .mem_data_out(mdo));
  end

  typedef struct {
    int k; logic s; logic [2:0] f; logic [31:0] a, wd; logic [4:0] rd;
    logic [31:0] m, xr; logic xe; logic [1:0] xc; int hold;
  } vec_t;
  vec_t v [13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  // Reference behaviour from the RV32I access rules, in plain arithmetic
  function automatic void model(input logic s, input logic [2:0] f, input logic [31:0] a, wd, m,
                                output logic e, output logic [1:0] c, output logic [31:0] r,
                                output logic [2:0] w, output logic [31:0] d);
    int sz;
    longint lim, val;
    logic ill;
    ill = f == 3 || f == 6 || f == 7 || (s && f >= 4);
    sz = 1 << (f % 4);
    if (sz > 4) sz = 4;
    c = ill ? 2'd2 : (a % sz != 0) ? 2'd1 : 2'd0;
    e = c != 0;
    lim = 64'd1 << (8 * sz);
    val = longint'(m) % lim;
    if (f < 4 && sz < 4 && val >= lim / 2) val -= lim;
    r = (s || e) ? 32'd0 : val[31:0];
    d = 32'(longint'(wd) % lim);
    w = sz == 1 ? 3'b100 : sz == 2 ? 3'b010 : 3'b001;
  endfunction

  task automatic txn(input int k, input logic s, input logic [2:0] f, input logic [31:0] a, wd,
                     input logic [4:0] rd, input logic [31:0] m, xr, input logic xe,
                     input logic [1:0] xc, input int hold);
    logic e2;
    logic [1:0] c2;
    logic [31:0] r2, din;
    logic [2:0] xwe;
    int lat, pulses, at;
    model(s, f, a, wd, m, e2, c2, r2, xwe, din);
    @(negedge clk);
    chk("req_ready idle", rdy[k], 1);
    req_store = s; req_funct3 = f; req_addr = a; req_wdata = wd; req_rd = rd; mdo = m;
    req_valid[k] = 1'b1;
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 0; pulses = 0; at = -1;
    while (!rv[k] && lat < 20) begin
      chk("mem_addr", maddr[k], a);
      chk("req_ready busy", rdy[k], 0);
      if (we[k] != 3'b000) begin
        pulses++; at = lat;
        chk("write_enable", we[k], xwe);
        chk("mem_data_in", mdin[k], din);
      end
      @(negedge clk);
      lat++;
    end
    chk("resp_valid", rv[k], 1);
    chk("latency", lat, xe ? 0 : k);
    chk("we pulses", pulses, (s && !xe) ? 1 : 0);
    if (s && !xe) chk("we cycle", at, k - 1);
    chk("resp_rdata", rdata[k], xr);
    chk("resp_rd", rrd[k], rd);
    chk("resp_error", rerr[k], xe);
    chk("resp_cause", cause[k], xc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold valid", rv[k], 1);
      chk("hold ready", rdy[k], 0);
      chk("hold rdata", rdata[k], xr);
      chk("hold rd", rrd[k], rd);
      chk("hold error", rerr[k], xe);
      chk("hold cause", cause[k], xc);
      chk("hold we", we[k], 0);
    end
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    chk("ready after handshake", rdy[k], 1);
    chk("valid after handshake", rv[k], 0);
  endtask

  initial begin
    logic s, e;
    logic [2:0] f, w;
    logic [31:0] a, wd, m, r, d;
    logic [1:0] c;
    int k;
    v[0]  = '{1, 0, 3'b010, 32'h10000004, 32'h0, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2'b00, 0};
    v[1]  = '{1, 0, 3'b000, 32'h10000003, 32'h0, 5'd6, 32'h000000F0, 32'hFFFFFFF0, 0, 2'b00, 0};
    v[2]  = '{1, 0, 3'b100, 32'h10000003, 32'h0, 5'd7, 32'h000000F0, 32'h000000F0, 0, 2'b00, 0};
    v[3]  = '{1, 0, 3'b001, 32'h10000002, 32'h0, 5'd8, 32'h00008001, 32'hFFFF8001, 0, 2'b00, 0};
    v[4]  = '{1, 1, 3'b001, 32'h10000002, 32'h12345678, 5'd9, 32'h0, 32'h0, 0, 2'b00, 0};
    v[5]  = '{1, 0, 3'b010, 32'h10000002, 32'h0, 5'd10, 32'h11111111, 32'h0, 1, 2'b01, 0};
    v[6]  = '{1, 0, 3'b011, 32'h10000000, 32'h0, 5'd11, 32'h11111111, 32'h0, 1, 2'b10, 0};
    v[7]  = '{3, 1, 3'b010, 32'h20000000, 32'hA5A5A5A5, 5'd12, 32'h0, 32'h0, 0, 2'b00, 4};
    v[8]  = '{2, 0, 3'b101, 32'h30000006, 32'h0, 5'd13, 32'hFFFF8001, 32'h00008001, 0, 2'b00, 1};
    v[9]  = '{1, 1, 3'b100, 32'h10000000, 32'h55, 5'd14, 32'h0, 32'h0, 1, 2'b10, 0};
    v[10] = '{1, 1, 3'b001, 32'h10000001, 32'h55, 5'd15, 32'h0, 32'h0, 1, 2'b01, 0};
    v[11] = '{1, 1, 3'b101, 32'h10000001, 32'h55, 5'd16, 32'h0, 32'h0, 1, 2'b10, 0};
    v[12] = '{1, 0, 3'b010, 32'hF0000000, 32'h0, 5'd17, 32'h00001234, 32'h00001234, 0, 2'b00, 2};
    rst = 1'b1;
    req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0; mdo = 0;
    for (int i = 1; i <= 3; i++) begin req_valid[i] = 0; resp_ready[i] = 0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      chk("rst req_ready", rdy[i], 1);
      chk("rst resp_valid", rv[i], 0);
      chk("rst resp_error", rerr[i], 0);
      chk("rst resp_cause", cause[i], 0);
      chk("rst resp_rdata", rdata[i], 0);
      chk("rst resp_rd", rrd[i], 0);
      chk("rst mem_addr", maddr[i], 0);
      chk("rst write_enable", we[i], 0);
      chk("rst mem_data_in", mdin[i], 0);
    end
    foreach (v[i])
      txn(v[i].k, v[i].s, v[i].f, v[i].a, v[i].wd, v[i].rd, v[i].m, v[i].xr, v[i].xe, v[i].xc, v[i].hold);
    // SB cut off by reset in its first ACCESS cycle (ACCESS_CYCLES=2)
    @(negedge clk);
    req_store = 1; req_funct3 = 3'b000; req_addr = 32'h10000001; req_wdata = 32'h000000AB; req_rd = 5'd3;
    req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("cut first cycle we", we[2], 0);
    rst = 1'b1;
    #1;
    chk("cut rst ready", rdy[2], 1);
    chk("cut rst valid", rv[2], 0);
    chk("cut rst we", we[2], 0);
    chk("cut rst mem_addr", maddr[2], 0);
    chk("cut rst data_in", mdin[2], 0);
    chk("cut rst resp_rd", rrd[2], 0);
    @(negedge clk);
    chk("cut rst held we", we[2], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cut after we", we[2], 0);
    chk("cut after valid", rv[2], 0);
    chk("cut after ready", rdy[2], 1);
    txn(2, 1, 3'b000, 32'h10000001, 32'h000000AB, 5'd3, 32'h0, 32'h0, 0, 2'b00, 0);
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(1, 3);
      s = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = {4'($urandom_range(0, 15)), 28'($urandom)};
      wd = $urandom;
      m = $urandom;
      model(s, f, a, wd, m, e, c, r, w, d);
      txn(k, s, f, a, wd, 5'($urandom), m, r, e, c, $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
